// File: rtl/axi_ram_slave_pkg.sv
// axi_ram_slave_pkg: FSM encodings and AXI constants shared by axi_ram_slave and its bench
package axi_ram_slave_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_e;

    localparam logic       PRIO_RD     = 1'b0;
    localparam logic       PRIO_WR     = 1'b1;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave serving one burst at a time from an external single-port byte-enabled RAM
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   axi_ar*/axi_r*  : read address / read data channels, one beat per cycle
//   axi_aw*/axi_w*  : write address / write data channels
//   axi_b*          : write response channel
//   mem_*           : RAM port; mem_rdata is valid the cycle after a read and held while mem_en=0
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = 14,
    localparam int BE_NBYTES = AXI_DATA_W / 8,
    localparam int BE_BYTE_W = $clog2(BE_NBYTES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [AXI_ADDR_W-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic [AXI_ID_W-1:0]   axi_arid,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [AXI_DATA_W-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic [AXI_ID_W-1:0]   axi_rid,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [AXI_ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic [AXI_ID_W-1:0]   axi_awid,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [AXI_DATA_W-1:0] axi_wdata,
    input  logic [BE_NBYTES-1:0]  axi_wstrb,
    input  logic                  axi_wlast,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    output logic [AXI_ID_W-1:0]   axi_bid,
    output logic                  mem_en,
    output logic [BE_NBYTES-1:0]  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [AXI_DATA_W-1:0] mem_wdata,
    input  logic [AXI_DATA_W-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic                  err_q, err_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  berr_q, berr_d;
    logic                  issue;
    logic                  in_range;
    logic                  unused_addr_bits;

    // Only the word-address slice of the byte address reaches the RAM.
    assign unused_addr_bits = ^{axi_araddr, axi_awaddr};

    // cnt_q counts issued read beats or accepted write beats; 9 bits so len=255 still terminates.
    assign in_range = cnt_q <= {1'b0, len_q};

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        berr_d      = berr_q;
        issue       = 1'b0;
        axi_arready = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = '0;
        case (state_q)
            IDLE: begin
                // Readies are held off while reset is asserted so no handshake can complete.
                axi_arready = reset && axi_arvalid && (!axi_awvalid || prio_q == PRIO_RD);
                axi_awready = reset && axi_awvalid && (!axi_arvalid || prio_q == PRIO_WR);
                if (axi_arvalid && axi_awvalid)
                    prio_d = (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
                if (axi_arready) begin
                    state_d = RD;
                    addr_d  = axi_araddr[MEM_ADDR_W+BE_BYTE_W-1:BE_BYTE_W];
                    len_d   = axi_arlen;
                    id_d    = axi_arid;
                    err_d   = (axi_arburst != BURST_INCR) || (axi_arsize != 3'(BE_BYTE_W));
                    cnt_d   = '0;
                    rlast_d = 1'b0;
                end else if (axi_awready) begin
                    state_d = WR;
                    addr_d  = axi_awaddr[MEM_ADDR_W+BE_BYTE_W-1:BE_BYTE_W];
                    len_d   = axi_awlen;
                    id_d    = axi_awid;
                    err_d   = (axi_awburst != BURST_INCR) || (axi_awsize != 3'(BE_BYTE_W));
                    cnt_d   = '0;
                end
            end
            RD: begin
                // A new read may launch only when the R register is empty or draining this cycle.
                issue    = in_range && (!rvalid_q || axi_rready);
                mem_en   = issue;
                rvalid_d = issue || (rvalid_q && !axi_rready);
                if (issue) begin
                    addr_d  = addr_q + MEM_ADDR_W'(1);
                    cnt_d   = cnt_q + 9'd1;
                    rlast_d = cnt_q == {1'b0, len_q};
                end
                if (rvalid_q && axi_rready && rlast_q) begin
                    state_d = IDLE;
                    rlast_d = 1'b0;
                end
            end
            WR: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    mem_en = 1'b1;
                    mem_we = in_range ? axi_wstrb : '0;
                    addr_d = addr_q + MEM_ADDR_W'(1);
                    // Saturate so an overlong burst never wraps back into range.
                    cnt_d  = cnt_q + {8'd0, !cnt_q[8]};
                    if (axi_wlast) begin
                        state_d = WRESP;
                        berr_d  = err_q || (cnt_q != {1'b0, len_q});
                    end
                end
            end
            WRESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prio_q   <= PRIO_RD;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            id_q     <= id_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            berr_q   <= berr_d;
        end
    end

    assign axi_rvalid = rvalid_q;
    assign axi_rlast  = rlast_q;
    assign axi_rdata  = mem_rdata;
    assign axi_rresp  = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid    = id_q;
    assign axi_bresp  = (state_q == WRESP && berr_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_bid    = id_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = axi_wdata;

endmodule
